// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle datapath: ALU op codes, PC source,
// ALU operand-B select and the memory bus state machine.
package mc_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0110;
    localparam logic [3:0] ALU_SUB  = 4'b1110;
    localparam logic [3:0] ALU_SLT  = 4'b1111;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RA     = 2'b11;

    localparam logic [1:0] SRCB_RB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_BUSY = 2'd1,
        BUS_DONE = 2'd2
    } bus_state_e;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: logic, add/sub with signed overflow, set-less-than and
// shifts of operand B by a 5-bit amount.
module mc_alu
    import mc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      shamt,
    input  logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            ovf
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;

    always_comb begin
        sum    = op_a + op_b;
        diff   = op_a - op_b;
        result = sum;
        ovf    = 1'b0;
        case (alu_ctrl)
            ALU_AND:  result = op_a & op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_XOR:  result = op_a ^ op_b;
            ALU_NOR:  result = ~(op_a | op_b);
            ALU_SUB: begin
                result = diff;
                ovf    = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
            end
            ALU_SLT:  result = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU: result = XLEN'(op_a < op_b);
            ALU_SLL:  result = op_b << shamt;
            ALU_SRL:  result = op_b >> shamt;
            ALU_SRA:  result = XLEN'($signed(op_b) >>> shamt);
            // ALU_ADD and every unassigned code add
            default: begin
                result = sum;
                ovf    = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
            end
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/mc_datapath_param.sv
// Multi-cycle datapath: PC/IR/MDR/RA/RB/ALUOut, 32-entry register file and a
// request/ack memory port; Stall freezes architectural state during an access.
module mc_datapath_param
    import mc_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 8,
    parameter int unsigned PCSTART = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IorD,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            MemToReg,
    input  logic            IRWrite,
    input  logic            ALUSrcA,
    input  logic            RegWrite,
    input  logic            RegDst,
    input  logic            PCSel,
    input  logic [1:0]      PCSource,
    input  logic [1:0]      ALUSrcB,
    input  logic [3:0]      ALUCtrl,
    output logic            Stall,
    output logic            Zero,
    output logic            Ovf,
    output logic [5:0]      Op,
    output logic [5:0]      Function,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    bus_state_e      state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d, addr_q, addr_d;
    logic            we_q, we_d, irw_q, irw_d;
    logic [XLEN-1:0] wdata_q, wdata_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [XLEN-1:0] ra_q, ra_d, rb_q, rb_d, aluout_q, aluout_d;
    logic [XLEN-1:0] rf_q [32];

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata, rd_a, rd_b, imm_sext, op_a, op_b, alu_result;
    logic [AW-1:0]   pc_temp;

    mc_alu #(.XLEN(XLEN)) u_alu (
        .op_a     (op_a),
        .op_b     (op_b),
        .shamt    (ir_q[10:6]),
        .alu_ctrl (ALUCtrl),
        .result   (alu_result),
        .zero     (Zero),
        .ovf      (Ovf)
    );

    // Operand and PC-source selection; r0 is forced to read zero
    always_comb begin
        rd_a     = (ir_q[25:21] == 5'd0) ? '0 : rf_q[ir_q[25:21]];
        rd_b     = (ir_q[20:16] == 5'd0) ? '0 : rf_q[ir_q[20:16]];
        imm_sext = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
        op_a     = ALUSrcA ? ra_q : XLEN'(pc_q);
        case (ALUSrcB)
            SRCB_RB:   op_b = rb_q;
            SRCB_FOUR: op_b = XLEN'(4);
            SRCB_IMM:  op_b = imm_sext;
            default:   op_b = imm_sext << 2;
        endcase
        case (PCSource)
            PCS_ALU:    pc_temp = AW'(alu_result);
            PCS_ALUOUT: pc_temp = AW'(aluout_q);
            PCS_JUMP:   pc_temp = {ir_q[AW-3:0], 2'b00};
            default:    pc_temp = AW'(ra_q);
        endcase
    end

    assign Stall     = ((state_q == BUS_IDLE) && (MemRead || MemWrite)) || (state_q == BUS_BUSY);
    assign mem_req   = (state_q == BUS_BUSY);
    assign mem_we    = (state_q == BUS_BUSY) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign Op        = ir_q[31:26];
    assign Function  = (ir_q[31:26] == 6'd0) ? ir_q[5:0] : 6'd0;

    // Bus FSM next state; a write wins over a simultaneous read
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        irw_d   = irw_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        case (state_q)
            BUS_IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = IorD ? aluout_q[AW-1:0] : pc_q;
                    we_d    = MemWrite;
                    wdata_d = rb_q;
                    irw_d   = IRWrite;
                    state_d = BUS_BUSY;
                end
            end
            BUS_BUSY: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                        if (irw_q) ir_d = mem_rdata;
                    end
                    state_d = BUS_DONE;
                end
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    // Architectural updates, all gated by Stall
    always_comb begin
        pc_d     = pc_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        aluout_d = aluout_q;
        rf_we    = 1'b0;
        rf_waddr = RegDst ? ir_q[15:11] : ir_q[20:16];
        rf_wdata = MemToReg ? mdr_q : aluout_q;
        if (!Stall) begin
            ra_d     = rd_a;
            rb_d     = rd_b;
            aluout_d = alu_result;
            if (PCSel) pc_d = pc_temp;
            rf_we    = RegWrite && (rf_waddr != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BUS_IDLE;
            pc_q     <= AW'(PCSTART);
            addr_q   <= '0;
            we_q     <= 1'b0;
            irw_q    <= 1'b0;
            wdata_q  <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            aluout_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            irw_q    <= irw_d;
            wdata_q  <= wdata_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            aluout_q <= aluout_d;
            if (rf_we) rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_mc_datapath_param.sv
// Directed bench for mc_datapath_param: bus handshake, ALU ops, register file
// and PC behaviour with hand-computed expectations.
module tb_mc_datapath_param;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst, PCSel;
    logic [1:0]  PCSource, ALUSrcB;
    logic [3:0]  ALUCtrl;
    logic        Stall, Zero, Ovf;
    logic [5:0]  Op, Function;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;

    mc_datapath_param #(.XLEN(32), .AW(8), .PCSTART(128)) dut (
        .clk(clk), .reset(reset), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSel(PCSel), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUCtrl(ALUCtrl), .Stall(Stall), .Zero(Zero), .Ovf(Ovf), .Op(Op),
        .Function(Function), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Completed write transactions seen on the bus
    always @(posedge clk) if (mem_req && mem_we && mem_ack) wr_cnt <= wr_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctrl;
        IorD = 0; MemRead = 0; MemWrite = 0; MemToReg = 0; IRWrite = 0;
        ALUSrcA = 0; RegWrite = 0; RegDst = 0; PCSel = 0;
        PCSource = 2'b00; ALUSrcB = 2'b00; ALUCtrl = 4'b0000;
    endtask

    // Zero-wait access from PC; ends in IDLE with controls cleared
    task automatic bus_access(input logic wr, input logic irw, input logic [31:0] data);
        MemRead = !wr; MemWrite = wr; IRWrite = irw; IorD = 0;
        tick;
        mem_ack = 1; mem_rdata = data;
        tick;
        mem_ack = 0; clr_ctrl;
        tick;
    endtask

    task automatic load_reg(input logic [4:0] r, input logic [31:0] val);
        bus_access(1'b0, 1'b1, {11'd0, r, 16'd0});
        bus_access(1'b0, 1'b0, val);
        RegWrite = 1; MemToReg = 1;
        tick;
        clr_ctrl;
    endtask

    initial begin
        logic [3:0]  ops   [11];
        logic [31:0] res   [11];
        logic        zr    [11];
        logic        ov    [11];

        clr_ctrl;
        mem_ack = 0; mem_rdata = '0; reset = 1;
        tick; tick;
        reset = 0;
        #1;
        check_eq("rst_pc", 32'(dut.pc_q), 32'd128);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_stall", 32'(Stall), 32'd0);
        check_eq("rst_ir", dut.ir_q, 32'd0);

        // Instruction fetch, ack in first BUSY cycle
        MemRead = 1; IRWrite = 1; #1;
        check_eq("fetch_stall_idle", 32'(Stall), 32'd1);
        tick;
        check_eq("fetch_stall_busy", 32'(Stall), 32'd1);
        check_eq("fetch_req", 32'(mem_req), 32'd1);
        check_eq("fetch_addr", 32'(mem_addr), 32'd128);
        mem_ack = 1; mem_rdata = 32'h2002000A;
        tick;
        mem_ack = 0; clr_ctrl; #1;
        check_eq("fetch_stall_done", 32'(Stall), 32'd0);
        check_eq("fetch_req_done", 32'(mem_req), 32'd0);
        check_eq("fetch_ir", dut.ir_q, 32'h2002000A);
        check_eq("fetch_op", 32'(Op), 32'h08);
        check_eq("fetch_func", 32'(Function), 32'd0);
        tick;

        // Signed overflow on ADD, none on SUB
        load_reg(5'd1, 32'h7FFFFFFF);
        bus_access(1'b0, 1'b1, 32'h00200001);
        check_eq("ra_r1", dut.ra_q, 32'h7FFFFFFF);
        check_eq("func_op0", 32'(Function), 32'd1);
        ALUSrcA = 1; ALUSrcB = SRCB_IMM; ALUCtrl = ALU_ADD; #1;
        check_eq("add_res", dut.alu_result, 32'h80000000);
        check_eq("add_ovf", 32'(Ovf), 32'd1);
        tick;
        check_eq("add_aluout", dut.aluout_q, 32'h80000000);
        ALUCtrl = ALU_SUB; #1;
        check_eq("sub_res", dut.alu_result, 32'h7FFFFFFE);
        check_eq("sub_ovf", 32'(Ovf), 32'd0);
        ALUCtrl = ALU_ADD; ALUSrcB = SRCB_IMM4; #1;
        check_eq("add_imm4", dut.alu_result, 32'h80000003);
        clr_ctrl;

        // RA=0, RB=0x80000000, shamt=4 across the op table
        load_reg(5'd3, 32'h80000000);
        bus_access(1'b0, 1'b1, 32'h00030100);
        check_eq("rb_r3", dut.rb_q, 32'h80000000);
        ops[0]  = ALU_SRA;  res[0]  = 32'hF8000000; zr[0]  = 0; ov[0]  = 0;
        ops[1]  = ALU_SRL;  res[1]  = 32'h08000000; zr[1]  = 0; ov[1]  = 0;
        ops[2]  = ALU_SLL;  res[2]  = 32'h00000000; zr[2]  = 1; ov[2]  = 0;
        ops[3]  = ALU_SLT;  res[3]  = 32'h00000000; zr[3]  = 1; ov[3]  = 0;
        ops[4]  = ALU_SLTU; res[4]  = 32'h00000001; zr[4]  = 0; ov[4]  = 0;
        ops[5]  = ALU_NOR;  res[5]  = 32'h7FFFFFFF; zr[5]  = 0; ov[5]  = 0;
        ops[6]  = ALU_OR;   res[6]  = 32'h80000000; zr[6]  = 0; ov[6]  = 0;
        ops[7]  = ALU_XOR;  res[7]  = 32'h80000000; zr[7]  = 0; ov[7]  = 0;
        ops[8]  = ALU_AND;  res[8]  = 32'h00000000; zr[8]  = 1; ov[8]  = 0;
        ops[9]  = ALU_SUB;  res[9]  = 32'h80000000; zr[9]  = 0; ov[9]  = 1;
        ops[10] = 4'b0100;  res[10] = 32'h80000000; zr[10] = 0; ov[10] = 0;
        ALUSrcA = 1; ALUSrcB = SRCB_RB;
        for (int i = 0; i < 11; i++) begin
            ALUCtrl = ops[i]; #1;
            check_eq($sformatf("alu_res_%0d", i), dut.alu_result, res[i]);
            check_eq($sformatf("alu_zero_%0d", i), 32'(Zero), 32'(zr[i]));
            check_eq($sformatf("alu_ovf_%0d", i), 32'(Ovf), 32'(ov[i]));
        end
        clr_ctrl;

        // Write-then-read of r5 through RA
        bus_access(1'b0, 1'b1, 32'h00A50000);
        bus_access(1'b0, 1'b0, 32'h12345678);
        RegWrite = 1; MemToReg = 1;
        tick;
        clr_ctrl;
        check_eq("wtr_old", dut.ra_q, 32'd0);
        check_eq("wtr_rf5", dut.rf_q[5], 32'h12345678);
        tick;
        check_eq("wtr_new", dut.ra_q, 32'h12345678);

        // Writes to r0 are discarded
        load_reg(5'd0, 32'd5);
        tick;
        check_eq("r0_ra", dut.ra_q, 32'd0);
        check_eq("r0_rf", dut.rf_q[0], 32'd0);

        // Jump to 252, then PC+4 wraps to 0
        bus_access(1'b0, 1'b1, 32'h00A5003F);
        check_eq("func_3f", 32'(Function), 32'h3F);
        PCSel = 1; PCSource = PCS_JUMP;
        tick;
        check_eq("pc_jump", 32'(dut.pc_q), 32'd252);
        PCSource = PCS_ALU; ALUSrcA = 0; ALUSrcB = SRCB_FOUR; ALUCtrl = ALU_ADD;
        tick;
        check_eq("pc_wrap", 32'(dut.pc_q), 32'd0);

        // Read with 4 wait cycles; PC/RA/regfile frozen while stalled
        MemRead = 1; RegWrite = 1; #1;
        check_eq("wait_stall_idle", 32'(Stall), 32'd1);
        tick;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("wait_req_%0d", i), 32'(mem_req), 32'd1);
            check_eq($sformatf("wait_addr_%0d", i), 32'(mem_addr), 32'd0);
            check_eq($sformatf("wait_pc_%0d", i), 32'(dut.pc_q), 32'd0);
            check_eq($sformatf("wait_ra_%0d", i), dut.ra_q, 32'h12345678);
            if (i == 4) begin
                mem_ack = 1; mem_rdata = 32'hCAFEF00D;
            end
            tick;
        end
        mem_ack = 0; MemRead = 0; RegWrite = 0; #1;
        check_eq("wait_done_stall", 32'(Stall), 32'd0);
        check_eq("wait_done_req", 32'(mem_req), 32'd0);
        check_eq("wait_mdr", dut.mdr_q, 32'hCAFEF00D);
        check_eq("wait_ir", dut.ir_q, 32'h00A5003F);
        tick;
        clr_ctrl;
        check_eq("wait_pc_after", 32'(dut.pc_q), 32'd4);
        check_eq("wait_rf5", dut.rf_q[5], 32'h12345678);

        // MemRead+MemWrite together: a single write, MDR untouched
        load_reg(5'd6, 32'hDEADBEEF);
        tick;
        check_eq("rb_r6", dut.rb_q, 32'hDEADBEEF);
        MemRead = 1; MemWrite = 1;
        tick;
        check_eq("wr_req", 32'(mem_req), 32'd1);
        check_eq("wr_we", 32'(mem_we), 32'd1);
        check_eq("wr_addr", 32'(mem_addr), 32'd4);
        check_eq("wr_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ack = 1; mem_rdata = 32'h11111111;
        tick;
        mem_ack = 0; clr_ctrl;
        tick; tick;
        check_eq("wr_count", 32'(wr_cnt), 32'd1);
        check_eq("wr_mdr", dut.mdr_q, 32'hDEADBEEF);
        check_eq("wr_idle_req", 32'(mem_req), 32'd0);

        // Reset during BUSY abandons the access; late ack ignored
        MemRead = 1; IRWrite = 1;
        tick;
        check_eq("rbusy_req", 32'(mem_req), 32'd1);
        reset = 1; clr_ctrl;
        tick;
        reset = 0; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        tick;
        mem_ack = 0; #1;
        check_eq("rbusy_state", 32'(dut.state_q), 32'(BUS_IDLE));
        check_eq("rbusy_req_after", 32'(mem_req), 32'd0);
        check_eq("rbusy_stall", 32'(Stall), 32'd0);
        check_eq("rbusy_ir", dut.ir_q, 32'd0);
        check_eq("rbusy_mdr", dut.mdr_q, 32'd0);
        check_eq("rbusy_pc", 32'(dut.pc_q), 32'd128);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_datapath_param.md
MC_DATAPATH_PARAM -- requirements
Module: mc_datapath_param

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data/register width (multiple of 8, >=32).
REQ-002 Parameters SHALL be: AW, default 8, byte-address width of PC and memory port.
REQ-003 Parameters SHALL be: PCSTART, default 128, PC reset value.
REQ-004 Ports SHALL be: clk  in  1  single clock, all state on posedge.
REQ-005 Ports SHALL be: reset  in  1  synchronous, active-high reset.
REQ-006 Ports SHALL be control inputs: IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst and PCSel, each 1 bit; PCSource, ALUSrcB  in  2; ALUCtrl  in  4.
REQ-007 Ports SHALL be: Stall  out  1  access in progress, controller holds its outputs.
REQ-008 Ports SHALL be: Zero, Ovf  out  1  ALUResult==0; signed add/sub overflow.
REQ-009 Ports SHALL be: Op, Function  out  6  IR[31:26]; IR[5:0] when Op==0, else 0.
REQ-010 Ports SHALL be: mem_req  out  1; mem_we  out  1; mem_addr  out  AW; mem_wdata  out  XLEN; mem_rdata  in  XLEN; mem_ack  in  1.

Function
REQ-011 Bus FSM SHALL have states IDLE, BUSY and DONE; Stall = (IDLE & (MemRead|MemWrite)) | BUSY.
REQ-012 IDLE SHALL, on MemRead|MemWrite: latch addr (IorD ? ALUOut[AW-1:0] : PC), we=MemWrite, wdata=RB and irw=IRWrite, then go BUSY; MemWrite has priority when both are asserted (no read).
REQ-013 BUSY SHALL drive mem_req=1 with addr/we/wdata held stable until mem_ack; on ack of a read, MDR<=mem_rdata and, if irw, IR<=mem_rdata; then go DONE.
REQ-014 DONE SHALL last exactly one cycle with Stall=0 and mem_req=0, then go IDLE; minimum access time SHALL be 3 cycles (ack in first BUSY cycle).
REQ-015 PC, RA, RB, ALUOut and register-file writes SHALL update only when Stall=0; PC loads PC_Temp when PCSel.
REQ-016 PC_Temp SHALL select by PCSource: 00 ALUResult, 01 ALUOut, 10 {IR[AW-3:0],2'b00}, 11 RA; all selections truncated to AW bits, PC wrapping modulo 2^AW.
REQ-017 OpA SHALL be ALUSrcA ? RA : zero-extended PC; OpB SHALL select by ALUSrcB: 00 RB, 01 4, 10 sign-extended IR[15:0], 11 sign-extended IR[15:0]<<2.
REQ-018 ALUCtrl SHALL select: 0000 AND, 0001 OR, 0010 XOR, 0011 NOR, 0110 ADD, 1110 SUB, 1111 SLT signed, 0111 SLTU, 1000 SLL, 1001 SRL, 1010 SRA (shift OpB by IR[10:6]); other codes ADD.
REQ-019 Ovf SHALL be valid for ADD/SUB only (0 otherwise); it SHALL be informational and SHALL NOT block writeback.
REQ-020 Register file SHALL hold 32 entries of XLEN bits, with 2 async reads (IR[25:21], IR[20:16]) and 1 sync write to RegDst ? IR[15:11] : IR[20:16] of MemToReg ? MDR : ALUOut.
REQ-021 Register 0 SHALL always read 0; writes to it SHALL be discarded.
REQ-022 Write-then-read of the same register SHALL return the old value in the write cycle and the new value the next cycle.

Reset
REQ-023 On reset: PC=PCSTART; IR, MDR, RA, RB, ALUOut and all registers = 0; FSM=IDLE.
REQ-024 On reset: mem_req=0, mem_we=0, Stall=0 next cycle.
REQ-025 Reset asserted during BUSY SHALL abandon the access; a later mem_ack SHALL be ignored while IDLE.

Structure
REQ-026 Package mc_pkg SHALL hold the ALUCtrl, PCSource and ALUSrcB code constants and the bus-state enum.
REQ-027 The ALU (ops, Zero, Ovf) SHALL be sub-module mc_alu, parameterised by XLEN.

Verification
REQ-028 Fetch, ack in first BUSY cycle, rdata=0x2002000A: Stall high 2 cycles; IR=0x2002000A; Op=0x08.
REQ-029 Read with 4 wait cycles: mem_req and mem_addr stable for 5 cycles; PC and RA unchanged until DONE.
REQ-030 MemRead+MemWrite together with RB=0xDEADBEEF: exactly one write; mem_wdata=0xDEADBEEF; MDR unchanged.
REQ-031 ADD of 0x7FFFFFFF+1: ALUResult=0x80000000, Ovf=1; SRA of 0x80000000 by 4 gives 0xF8000000.
REQ-032 PC=252, PCSource=00, ALUSrcB=01, PCSel, AW=8: PC wraps to 0; RegWrite to r0 with 5: r0 still reads 0.
REQ-033 Reset pulsed in BUSY, then mem_ack: FSM IDLE, mem_req=0, IR unchanged (0), PC=PCSTART.
